// File: rtl/cosine_arbiter.sv
// cosine_arbiter: round-robin sharing of one cosine core
// between NUM_REQ requesters, with a hung-core watchdog.
module cosine_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_theta,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_result,
  output logic                      resp_error,
  output logic                      core_start,
  output logic [DATA_W-1:0]         core_theta,
  input  logic                      core_done,
  input  logic [DATA_W-1:0]         core_result,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_id
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] QNAN = DATA_W'(32'h7FC0_0000);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } stateT;

  stateT state;
  stateT stateNext;

  logic [IDX_W-1:0]   rrPtr;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   cand;
  logic               hit;
  logic [CNT_W-1:0]   wdCnt;
  logic               wdHit;
  logic [NUM_REQ-1:0] grantOh;
  logic [DATA_W-1:0]  thetaArr [NUM_REQ];

  function automatic logic [IDX_W-1:0] wrapInc(
    input logic [IDX_W-1:0] v
  );
    return (v == IDX_W'(NUM_REQ - 1)) ? '0 : v + IDX_W'(1);
  endfunction

  // unpack the flat operand bus into one word per requester
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      thetaArr[i] = req_theta[i*DATA_W +: DATA_W];
    end
  end

  // first pending requester at or above rrPtr, wrapping around
  always_comb begin
    hit  = 1'b0;
    pick = rrPtr;
    cand = rrPtr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hit && req_valid[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
      cand = wrapInc(cand);
    end
  end

  assign wdHit = (TIMEOUT != 0) && (wdCnt == CNT_LAST);

  // state register; clk_en low freezes the sequencer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= stateNext;
    end
  end

  // next-state: done beats the watchdog on the final count
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (hit) stateNext = ISSUE;
      ISSUE:   stateNext = WAIT;
      WAIT:    if (core_done || wdHit) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // grant capture, watchdog and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rrPtr       <= '0;
      grant_id    <= '0;
      core_theta  <= '0;
      wdCnt       <= '0;
      resp_result <= '0;
      resp_error  <= 1'b0;
    end else if (clk_en) begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            core_theta <= thetaArr[pick];
            grant_id   <= pick;
            rrPtr      <= wrapInc(pick);
          end
        end
        ISSUE: wdCnt <= '0;
        WAIT: begin
          if (core_done) begin
            resp_result <= core_result;
            resp_error  <= 1'b0;
          end else if (wdHit) begin
            resp_result <= QNAN;
            resp_error  <= 1'b1;
          end else begin
            wdCnt <= wdCnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign grantOh    = NUM_REQ'(1) << grant_id;
  assign core_start = (state == ISSUE);
  assign busy       = (state != IDLE);
  assign req_ack    = core_start ? grantOh : '0;
  assign resp_valid = (state == RESP) ? grantOh : '0;

endmodule

// File: doc/cosine_arbiter.md
Name: cosine_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one floating-point cosine core between NUM_REQ requesters (Nios II custom-instruction masters or hardware accelerators).
- Drives the core's start/done handshake and returns each result to the requester that issued it.
- A watchdog aborts a hung operation so that the other requesters are not starved.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, operand/result width (IEEE-754 single)
TIMEOUT, 255, maximum WAIT cycles before abort; 0 disables the watchdog
IDX_W, $clog2(NUM_REQ), derived grant index width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
clk_en  in  1  global enable; low freezes all state and registered outputs
req_valid  in  NUM_REQ  request i pending; held until req_ack[i]
req_theta  in  NUM_REQ*DATA_W  operand of requester i at [i*DATA_W +: DATA_W]
req_ack  out  NUM_REQ  one-hot, 1-cycle pulse; operand accepted
resp_valid  out  NUM_REQ  one-hot, 1-cycle pulse; result ready
resp_result  out  DATA_W  result; valid while any resp_valid bit is high
resp_error  out  1  high with resp_valid when the operation timed out
core_start  out  1  1-cycle start pulse to the cosine core
core_theta  out  DATA_W  registered operand to the core, stable from ISSUE until the next grant
core_done  in  1  core completion strobe
core_result  in  DATA_W  core result, sampled when core_done is high
busy  out  1  high in any state other than IDLE
grant_id  out  IDX_W  index of the current or last granted requester

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_ptr=0.
  - All outputs 0, including core_theta, resp_result and grant_id.
  - Takes effect immediately, including mid-operation; any in-flight result is discarded.
- clk_en=0: state, rr_ptr, watchdog counter and all registered outputs hold. core_done is ignored in that cycle.
- All transitions below occur only on clock edges with clk_en=1.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req_valid≠0, grant g = the first set bit found searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - On that edge: core_theta←req_theta[g], grant_id←g, rr_ptr←(g+1) mod NUM_REQ, go to ISSUE.
  - If req_valid=0, stay in IDLE.
- ISSUE (exactly 1 cycle): core_start=1 and req_ack[g]=1; watchdog cleared; go to WAIT. core_done in this cycle is discarded as stale.
- WAIT:
  - core_done=1: resp_result←core_result, resp_error←0, go to RESP.
  - Otherwise the watchdog increments. If TIMEOUT≠0 and counter==TIMEOUT-1: resp_result←32'h7FC00000 (quiet NaN), resp_error←1, go to RESP. WAIT therefore lasts at most TIMEOUT cycles.
  - If core_done arrives on the final count, the success path wins.
- RESP (exactly 1 cycle): resp_valid[g]=1, go to IDLE.
  - resp_result and resp_error hold until the next RESP.
  - core_done in RESP or IDLE is discarded.
- Latency:
  - Request sampled at edge k → req_ack and core_start during cycle k+1.
  - core_done sampled at edge m → resp_valid during cycle m+1.
  - Earliest next grant sampled at edge m+2.
- One operation in flight at a time; no queuing.
- A requester that deasserts req_valid before its ack is simply not granted; no error is flagged.
- req_valid bits for non-granted requesters are ignored outside IDLE.
- Fairness: a continuously requesting requester is served within NUM_REQ grants.

Test Plan:
- Single request: req_valid=4'b0001, theta=32'hbf451eb8; core model asserts done 10 cycles after start with result 32'h3F380000.
  - req_ack[0] and core_start are each high for exactly 1 cycle at k+1; core_theta=32'hbf451eb8.
  - resp_valid[0]=1 one cycle after done; resp_result=32'h3F380000; resp_error=0; grant_id=0.
- All four requesters held valid, distinct thetas 32'h3F000000..32'h3F000003, fixed core latency 5 → grant order 0,1,2,3,0. Each resp_valid carries the matching result. busy drops for exactly 1 IDLE cycle between operations.
- Round-robin pointer: after a grant to 2, assert req_valid=4'b1010 → grant 3, then 1.
- Watchdog: TIMEOUT=8, core never asserts done.
  - resp_valid[g] high after exactly 8 WAIT cycles with resp_error=1 and resp_result=32'h7FC00000.
  - A subsequent request is granted normally. done asserted on the 8th WAIT cycle → success, resp_error=0.
- clk_en=0 for 5 cycles during WAIT with TIMEOUT=8: the watchdog freezes, so the error pulse is delayed by exactly 5 cycles. core_done pulsed while clk_en=0 is ignored.
- Drop reset (to 0) asynchronously mid-WAIT: all outputs are 0 immediately. After release, req_valid=4'b1100 → grant 2 (rr_ptr=0).
